// File: rtl/debounce_multi.sv
// N-channel push-button debouncer: 2-flop synchroniser, stability filter, press/release pulses.
// Long-press pulses are built only when LONG_PRESS_EN is defined; otherwise long_o is tied to 0.
module debounce_multi #(
    parameter int unsigned CHANNELS        = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 270000,
    parameter int unsigned ACTIVE_LOW      = 1,
    parameter int unsigned LONG_CYCLES     = 27000000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn_i,
    output logic [CHANNELS-1:0] level_o,
    output logic [CHANNELS-1:0] rise_o,
    output logic [CHANNELS-1:0] fall_o,
    output logic [CHANNELS-1:0] long_o
);

    localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    if (CHANNELS < 1 || DEBOUNCE_CYCLES < 1 || LONG_CYCLES < 1) begin : g_bad_params
        $error("debounce_multi: CHANNELS, DEBOUNCE_CYCLES and LONG_CYCLES must be >= 1");
    end

    logic [CHANNELS-1:0] pressed_raw;
    logic [CHANNELS-1:0] sync1;
    logic [CHANNELS-1:0] sync2;
    logic [CHANNELS-1:0] accept_c;
    logic [CNT_W-1:0]    cnt [CHANNELS];

    assign pressed_raw = (ACTIVE_LOW != 0) ? ~btn_i : btn_i;

    // Synchroniser; reset value is the not-pressed level.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pressed_raw;
            sync2 <= sync1;
        end
    end

    // A change is accepted on the last of DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        accept_c = '0;
        for (int ch = 0; ch < CHANNELS; ch++) begin
            accept_c[ch] = (sync2[ch] != level_o[ch]) && (cnt[ch] == CNT_LAST);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_o <= '0;
            rise_o  <= '0;
            fall_o  <= '0;
            cnt     <= '{default: '0};
        end else begin
            level_o <= level_o ^ accept_c;
            rise_o  <= accept_c & sync2;
            fall_o  <= accept_c & ~sync2;
            for (int ch = 0; ch < CHANNELS; ch++) begin
                if ((sync2[ch] == level_o[ch]) || accept_c[ch]) begin
                    cnt[ch] <= '0;
                end else begin
                    cnt[ch] <= cnt[ch] + CNT_W'(1);
                end
            end
        end
    end

`ifdef LONG_PRESS_EN
    localparam int unsigned       LONG_W   = $clog2(LONG_CYCLES + 1);
    localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES);

    logic [LONG_W-1:0] hold [CHANNELS];

    // Hold counter saturates at LONG_MAX so the pulse fires once per press.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            long_o <= '0;
            hold   <= '{default: '0};
        end else begin
            for (int ch = 0; ch < CHANNELS; ch++) begin
                long_o[ch] <= level_o[ch] && (hold[ch] == LONG_MAX - LONG_W'(1));
                if (!level_o[ch]) begin
                    hold[ch] <= '0;
                end else if (hold[ch] != LONG_MAX) begin
                    hold[ch] <= hold[ch] + LONG_W'(1);
                end
            end
        end
    end
`else
    assign long_o = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Self-checking bench for debounce_multi (CHANNELS=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, LONG_CYCLES=10).
// Long-press expectations follow whether LONG_PRESS_EN is defined for the build.
module tb_debounce_multi;

`ifdef LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] btn_i;
    logic [1:0] level_o;
    logic [1:0] rise_o;
    logic [1:0] fall_o;
    logic [1:0] long_o;

    int checks   = 0;
    int failures = 0;

    debounce_multi #(
        .CHANNELS       (2),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW     (1),
        .LONG_CYCLES    (10)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (btn_i),
        .level_o(level_o),
        .rise_o (rise_o),
        .fall_o (fall_o),
        .long_o (long_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [1:0] btn;
        logic [1:0] level;
        logic [1:0] rise;
        logic [1:0] fall;
    } vec_t;

    vec_t tbl [30];

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Drive inputs, let one posedge pass, then compare the registered outputs.
    task automatic step(input logic r, input logic [1:0] b, input logic [1:0] el,
                        input logic [1:0] er, input logic [1:0] ef,
                        input logic [1:0] elong, input bit chk_long, input string tag);
        rst_n = r;
        btn_i = b;
        @(posedge clk);
        #1;
        check({tag, ".level"}, level_o, el);
        check({tag, ".rise"},  rise_o,  er);
        check({tag, ".fall"},  fall_o,  ef);
        if (!LONG_EN || chk_long) check({tag, ".long"}, long_o, elong);
    endtask

    initial begin
        rst_n = 1'b0;
        btn_i = 2'b00;

        // Reset with both pressed, release reset, both accepted, release both, press ch0, release ch0.
        for (int i = 0; i < 3; i++)   tbl[i] = '{1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
        for (int i = 3; i < 8; i++)   tbl[i] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[8]  = '{1'b1, 2'b00, 2'b11, 2'b11, 2'b00};
        tbl[9]  = '{1'b1, 2'b00, 2'b11, 2'b00, 2'b00};
        for (int i = 10; i < 15; i++) tbl[i] = '{1'b1, 2'b11, 2'b11, 2'b00, 2'b00};
        tbl[15] = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b11};
        tbl[16] = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b00};
        for (int i = 17; i < 22; i++) tbl[i] = '{1'b1, 2'b10, 2'b00, 2'b00, 2'b00};
        tbl[22] = '{1'b1, 2'b10, 2'b01, 2'b01, 2'b00};
        tbl[23] = '{1'b1, 2'b10, 2'b01, 2'b00, 2'b00};
        for (int i = 24; i < 29; i++) tbl[i] = '{1'b1, 2'b11, 2'b01, 2'b00, 2'b00};
        tbl[29] = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b01};

        for (int i = 0; i < 30; i++) begin
            step(tbl[i].rst, tbl[i].btn, tbl[i].level, tbl[i].rise, tbl[i].fall,
                 2'b00, 1'b1, $sformatf("tbl%0d", i));
        end

        // Bounce on ch0: 3-clock runs never reach the 4-sample threshold.
        for (int k = 0; k < 30; k++) begin
            logic [1:0] b;
            b = {1'b1, ((k / 3) % 2 == 0) ? 1'b0 : 1'b1};
            step(1'b1, b, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, $sformatf("bounce%0d", k));
        end
        for (int k = 0; k < 4; k++)
            step(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, $sformatf("bounce_tail%0d", k));

        // Press ch1, then ch0 press and ch1 release on the same clock.
        for (int k = 1; k <= 6; k++)
            step(1'b1, 2'b01, (k == 6) ? 2'b10 : 2'b00, (k == 6) ? 2'b10 : 2'b00, 2'b00,
                 2'b00, 1'b1, $sformatf("ch1_press%0d", k));
        for (int k = 1; k <= 6; k++)
            step(1'b1, 2'b10, (k == 6) ? 2'b01 : 2'b10, (k == 6) ? 2'b01 : 2'b00,
                 (k == 6) ? 2'b10 : 2'b00, 2'b00, 1'b1, $sformatf("swap%0d", k));
        step(1'b1, 2'b10, 2'b01, 2'b00, 2'b00, 2'b00, 1'b1, "swap_after");
        for (int k = 1; k <= 6; k++)
            step(1'b1, 2'b11, (k == 6) ? 2'b00 : 2'b01, 2'b00, (k == 6) ? 2'b01 : 2'b00,
                 2'b00, 1'b1, $sformatf("ch0_release%0d", k));

        // Reset in the middle of a count discards it; filtering restarts from zero.
        step(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, "midcnt1");
        step(1'b1, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, "midcnt2");
        step(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, "midcnt_rst");
        for (int k = 1; k <= 6; k++)
            step(1'b1, 2'b10, (k == 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00, 2'b00,
                 2'b00, 1'b1, $sformatf("post_rst%0d", k));

        // Reset while ch0 is accepted as pressed clears the level.
        step(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, "lvl_rst");
        for (int k = 1; k <= 6; k++)
            step(1'b1, 2'b10, (k == 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00, 2'b00,
                 2'b00, 1'b1, $sformatf("repress%0d", k));

        // Long press: one pulse 10 clocks after rise, none after; re-arms after release.
        for (int rep = 0; rep < 2; rep++) begin
            for (int k = 1; k <= 14; k++)
                step(1'b1, 2'b10, 2'b01, 2'b00, 2'b00,
                     (LONG_EN && k == 10) ? 2'b01 : 2'b00, 1'b1, $sformatf("hold%0d_%0d", rep, k));
            for (int k = 1; k <= 6; k++)
                step(1'b1, 2'b11, (k == 6) ? 2'b00 : 2'b01, 2'b00, (k == 6) ? 2'b01 : 2'b00,
                     2'b00, 1'b1, $sformatf("long_rel%0d_%0d", rep, k));
            for (int k = 1; k <= 6; k++)
                step(1'b1, 2'b10, (k == 6) ? 2'b01 : 2'b00, (k == 6) ? 2'b01 : 2'b00, 2'b00,
                     2'b00, 1'b1, $sformatf("long_press%0d_%0d", rep, k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
